test_monitor: RTL and testbench
===============================

# test_monitor

- Synthesizable run controller and write-back tracer that sits between the bench and the `sopc` top level.
- It sequences the CPU reset and counts run cycles.
- It captures every architectural register write into a trace FIFO, and ends the run with a pass, fail or timeout verdict.
- Reset length, timeout, trace depth and the pass/fail signature are parameters, so a test needs no hard-coded delays or `$stop` times.

## Interface
- `DATA_WIDTH`, 32, register data width
- `REG_ADDR_WIDTH`, 5, register index width
- `CYCLE_WIDTH`, 32, cycle counter width
- `TRACE_DEPTH`, 16, FIFO entries; power of two, ≥2
- `RESET_CYCLES`, 10, cycles `cpu_reset` is held per run; ≥1
- `TIMEOUT_CYCLES`, 50, run cycles before timeout; ≥1
- `PASS_REG`, 2, register index watched for the verdict
- `PASS_VALUE`, 32'h600D600D, pass signature
- `FAIL_VALUE`, 32'hBADBAD00, fail signature

Ports:
- `clock`  in  1  single clock
- `reset`  in  1  asynchronous, active-low
- `start`  in  1  begin a run; sampled in IDLE or DONE only
- `cpu_reset`  out  1  active-high reset to `sopc`
- `wb_write`  in  1  register write strobe from the CPU write-back stage
- `wb_address`  in  `REG_ADDR_WIDTH`  written register
- `wb_data`  in  `DATA_WIDTH`  written value
- `trace_valid`  out  1  FIFO head is valid
- `trace_ready`  in  1  consumer pops the head
- `trace_cycle`  out  `CYCLE_WIDTH`  run cycle of the head entry
- `trace_address`  out  `REG_ADDR_WIDTH`  head register index
- `trace_data`  out  `DATA_WIDTH`  head value
- `cycle_count`  out  `CYCLE_WIDTH`  current run cycle
- `dropped`  out  8  entries lost to a full FIFO; saturates at 255
- `done`, `pass`, `fail`, `timeout`  out  1 each  verdict flags

## Operation
- **States:** IDLE → RESET_HOLD → RUN → DONE; DONE → RESET_HOLD on `start`.
- **`reset` low (async):**
  - state IDLE, `cpu_reset`=1
  - `cycle_count`=0, `dropped`=0, all flags 0
  - FIFO empty, `trace_valid`=0
- **IDLE:** `cpu_reset`=1. On `start`, go to RESET_HOLD.
- **On entering RESET_HOLD:**
  - FIFO flushed; `dropped`, `cycle_count` and flags cleared
  - the hold counter loads 0
- **RESET_HOLD:**
  - `cpu_reset`=1 for exactly `RESET_CYCLES` cycles, then go to RUN
  - `start` is ignored
- **RUN:**
  - `cpu_reset`=0
  - `cycle_count` is 0 in the first RUN cycle and increments each cycle
- **Trace capture (RUN only):**
  - every `wb_write` with `wb_address`≠0 pushes {`cycle_count`, `wb_address`, `wb_data`}
  - writes to register 0 are ignored
- **Verdict (RUN only):**
  - `wb_write` to `PASS_REG` with `PASS_VALUE` sets `pass`
  - with `FAIL_VALUE` it sets `fail`
  - any other value to `PASS_REG` is only traced
- **Timeout:** if `cycle_count` = `TIMEOUT_CYCLES`−1 and there is no verdict write that cycle, set `timeout`.
- **Any verdict:** sets `done`, goes to DONE, and reasserts `cpu_reset`=1 to freeze the CPU. The verdict write itself is traced.
- **DONE:**
  - flags and `cycle_count` hold
  - the FIFO keeps draining
  - `start` launches a new run
- **FIFO:**
  - first-word-fall-through; outputs show the head whenever `trace_valid`=1
  - pop on `trace_valid && trace_ready`
- **Full FIFO:**
  - a push without a same-cycle pop is dropped and `dropped` increments
  - a push with a same-cycle pop is accepted
- **`start` during RUN or RESET_HOLD:** ignored.

## Timing
- `start` high in cycle N puts the block in RESET_HOLD at N+1.
- `cpu_reset` goes low at N+1+`RESET_CYCLES` (registered output).
- A push in cycle K gives `trace_valid`=1 at K+1 if the FIFO was empty.
- A verdict write in cycle K sets the flags, `done` and `cpu_reset`=1 at K+1. `cycle_count` freezes at its cycle-K value.
- On timeout, `done` and `timeout` assert one cycle after `cycle_count` = `TIMEOUT_CYCLES`−1.
- A verdict write in the final cycle beats timeout: `pass` or `fail` is set, `timeout`=0.
- Flags are mutually exclusive; exactly one of `pass`, `fail`, `timeout` accompanies `done`.
- FIFO pointers are `log2(TRACE_DEPTH)`+1 bits and wrap modulo 2·`TRACE_DEPTH`.
  - full when the MSBs differ and the rest match
  - empty when the pointers are equal
- Async `reset` mid-run returns every output to its reset value immediately. Trace contents are lost.

## Test plan
- **Reset sequencing:** release `reset`, pulse `start` at cycle 3 → `cpu_reset`=1 in cycles 4–13, 0 from cycle 14; `cycle_count`=0 at cycle 14.
- **Pass:** in RUN, write reg 5=0x11 at run cycle 2, then reg 2=0x600D600D at cycle 7 → `done`=`pass`=1 next cycle. Trace pops in order (2,5,0x11) then (7,2,0x600D600D). `cycle_count` holds at 7.
- **Fail vs. timeout:** write reg 2=0xBADBAD00 at cycle 49 → `fail`=1, `timeout`=0. In a separate run with no writes → `timeout`=1 after `cycle_count`=49.
- **Overflow:** `trace_ready`=0, 20 writes to reg 3 → `trace_valid`=1, 16 entries retained (the first 16), `dropped`=4. A write coinciding with a pop while full is accepted.
- **Register 0 and idle filtering:** write reg 0 in RUN, and reg 4 during RESET_HOLD → FIFO stays empty.
- **Async reset mid-run and restart:** pull `reset` low at run cycle 20 → all outputs are at reset values without waiting for a clock edge. A `start` from DONE flushes the stale trace and clears `dropped`.

Source files
------------

// File: rtl/test_monitor.sv
// test_monitor: run controller and write-back tracer placed between a bench and the sopc top.
// Sequences the CPU reset, counts run cycles, traces every architectural register write into a
// first-word-fall-through FIFO, and ends each run with a pass, fail or timeout verdict.
//
// Ports:
//   clock, reset         single clock, asynchronous active-low reset
//   start                begin a run (sampled in IDLE or DONE only)
//   cpu_reset            active-high reset to the CPU, registered
//   wb_write/address/data  register write-back strobe, index and value
//   trace_valid/ready    FIFO head handshake; pop on valid && ready
//   trace_cycle/address/data  head entry contents (zero while trace_valid is low)
//   cycle_count          current run cycle
//   dropped              entries lost to a full FIFO, saturating at 255
//   done, pass, fail, timeout  verdict flags
module test_monitor #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CYCLE_WIDTH    = 32,
  parameter int unsigned TRACE_DEPTH    = 16,
  parameter int unsigned RESET_CYCLES   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 50,
  parameter int unsigned PASS_REG       = 2,
  parameter logic [DATA_WIDTH-1:0] PASS_VALUE = 32'h600D600D,
  parameter logic [DATA_WIDTH-1:0] FAIL_VALUE = 32'hBADBAD00
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      cpu_reset,
  input  logic                      wb_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_address,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [CYCLE_WIDTH-1:0]    trace_cycle,
  output logic [REG_ADDR_WIDTH-1:0] trace_address,
  output logic [DATA_WIDTH-1:0]     trace_data,
  output logic [CYCLE_WIDTH-1:0]    cycle_count,
  output logic [7:0]                dropped,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] RESET_HOLD = 2'd1;
  localparam logic [1:0] RUN        = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  localparam int unsigned AW = $clog2(TRACE_DEPTH);
  localparam int unsigned HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [REG_ADDR_WIDTH-1:0] PassReg   = REG_ADDR_WIDTH'(PASS_REG);
  localparam logic [HW-1:0]             HoldLast  = HW'(RESET_CYCLES - 1);
  localparam logic [CYCLE_WIDTH-1:0]    CycleLast = CYCLE_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   fail_q, fail_d;
  logic                   timeout_q, timeout_d;
  logic                   cpu_reset_q;
  logic [7:0]             dropped_q, dropped_d;
  logic [AW:0]            wptr_q, wptr_d;
  logic [AW:0]            rptr_q, rptr_d;

  logic [CYCLE_WIDTH-1:0]    mem_cycle [TRACE_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] mem_addr  [TRACE_DEPTH];
  logic [DATA_WIDTH-1:0]     mem_data  [TRACE_DEPTH];

  logic flush;
  logic in_run;
  logic pass_hit, fail_hit;
  logic push, pop, accept;
  logic empty, full;

  assign in_run   = (state_q == RUN);
  assign pass_hit = in_run && wb_write && (wb_address == PassReg) && (wb_data == PASS_VALUE);
  assign fail_hit = in_run && wb_write && (wb_address == PassReg) && (wb_data == FAIL_VALUE);

  // Write-back capture: register 0 is hard-wired, so its writes carry no information.
  assign push   = in_run && wb_write && (wb_address != '0);
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop    = !empty && trace_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign accept = push && (!full || pop);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cycle_d   = cycle_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    flush     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RESET_HOLD;
          flush   = 1'b1;
        end
      end
      RESET_HOLD: begin
        if (hold_q == HoldLast) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        // A verdict write in the final cycle takes priority over timeout.
        if (pass_hit) begin
          pass_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (fail_hit) begin
          fail_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cycle_q == CycleLast) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          cycle_d = cycle_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      hold_d    = '0;
      cycle_d   = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
    end
  end

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    dropped_d = dropped_q;
    if (flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      dropped_d = '0;
    end else begin
      if (accept) wptr_d = wptr_q + 1'b1;
      if (pop)    rptr_d = rptr_q + 1'b1;
      if (push && !accept && (dropped_q != 8'hFF)) dropped_d = dropped_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      cycle_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      dropped_q   <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cycle_q     <= cycle_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      // The CPU runs only while RUN is the next state, which keeps cpu_reset glitch-free.
      cpu_reset_q <= (state_d != RUN);
      dropped_q   <= dropped_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_cycle[wptr_q[AW-1:0]] <= cycle_q;
      mem_addr[wptr_q[AW-1:0]]  <= wb_address;
      mem_data[wptr_q[AW-1:0]]  <= wb_data;
    end
  end

  assign trace_valid   = !empty;
  assign trace_cycle   = trace_valid ? mem_cycle[rptr_q[AW-1:0]] : '0;
  assign trace_address = trace_valid ? mem_addr[rptr_q[AW-1:0]] : '0;
  assign trace_data    = trace_valid ? mem_data[rptr_q[AW-1:0]] : '0;

  assign cpu_reset   = cpu_reset_q;
  assign cycle_count = cycle_q;
  assign dropped     = dropped_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: directed runs, trace entries checked through a scoreboard queue.
module tb_test_monitor;

  localparam int unsigned RC = 10;
  localparam logic [31:0] PASS_V = 32'h600D600D;
  localparam logic [31:0] FAIL_V = 32'hBADBAD00;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cpu_reset;
  logic        wb_write = 1'b0;
  logic [4:0]  wb_address = '0;
  logic [31:0] wb_data = '0;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [31:0] trace_cycle;
  logic [4:0]  trace_address;
  logic [31:0] trace_data;
  logic [31:0] cycle_count;
  logic [7:0]  dropped;
  logic        done, pass, fail, timeout;

  int errors = 0;
  int checks = 0;
  int rc = 0;
  logic [68:0] exp_q[$];

  test_monitor dut (
    .clock(clock), .reset(reset), .start(start), .cpu_reset(cpu_reset),
    .wb_write(wb_write), .wb_address(wb_address), .wb_data(wb_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_cycle(trace_cycle),
    .trace_address(trace_address), .trace_data(trace_data), .cycle_count(cycle_count),
    .dropped(dropped), .done(done), .pass(pass), .fail(fail), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares every entry as it leaves the FIFO.
  always @(negedge clock) begin
    if (reset && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL trace_unexpected: got %h, expected none",
                 {trace_cycle, trace_address, trace_data});
      end else begin
        check("trace_entry", {trace_cycle, trace_address, trace_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulses start, verifies the flush and the reset-hold window, leaves the bench in run cycle 0.
  task automatic run_start(input logic hold_write);
    exp_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("flush_valid", trace_valid, 1'b0);
    check("flush_dropped", dropped, 8'd0);
    check("flush_done", {done, pass, fail, timeout}, 4'b0000);
    check("flush_cycle", cycle_count, 32'd0);
    wb_write   = hold_write;
    wb_address = 5'd4;
    wb_data    = 32'h44;
    for (int i = 0; i < RC; i++) begin
      check("hold_cpu_reset", cpu_reset, 1'b1);
      tick();
    end
    wb_write = 1'b0;
    check("run_cpu_reset", cpu_reset, 1'b0);
    check("run_cycle0", cycle_count, 32'd0);
    rc = 0;
  endtask

  task automatic run_cycle(input logic wr, input logic [4:0] a, input logic [31:0] d,
                           input logic expect_push);
    wb_write   = wr;
    wb_address = a;
    wb_data    = d;
    if (expect_push) exp_q.push_back({32'(rc), a, d});
    tick();
    wb_write = 1'b0;
    rc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !trace_valid) break;
      tick();
    end
    check("drain_queue", 69'(exp_q.size()), 69'd0);
    check("drain_valid", trace_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_flags", {done, pass, fail, timeout}, 4'b0000);
    check("rst_valid", trace_valid, 1'b0);
    check("rst_counts", {cycle_count, dropped}, 40'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    tick();
    tick();
    check("idle_cpu_reset", cpu_reset, 1'b1);

    // Pass run with trace
    trace_ready = 1'b1;
    run_start(1'b0);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 0);
    run_cycle(1, 5'd5, 32'h11, 1);
    for (int i = 3; i < 7; i++) run_cycle(0, 0, 0, 0);
    check("pass_pre_done", done, 1'b0);
    run_cycle(1, 5'd2, PASS_V, 1);
    check("pass_flags", {done, pass, fail, timeout}, 4'b1100);
    check("pass_cpu_reset", cpu_reset, 1'b1);
    check("pass_cycle", cycle_count, 32'd7);
    tick();
    tick();
    check("pass_cycle_hold", cycle_count, 32'd7);
    drain();

    // Fail in the final cycle beats timeout; a non-signature value is only traced
    run_start(1'b0);
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 0, 0);
    run_cycle(1, 5'd2, 32'h1234, 1);
    while (rc < 49) run_cycle(0, 0, 0, 0);
    check("fail_pre_done", done, 1'b0);
    check("fail_pre_cycle", cycle_count, 32'd49);
    run_cycle(1, 5'd2, FAIL_V, 1);
    check("fail_flags", {done, pass, fail, timeout}, 4'b1010);
    check("fail_cycle", cycle_count, 32'd49);
    drain();

    // Timeout with no writes
    run_start(1'b0);
    while (rc < 49) run_cycle(0, 0, 0, 0);
    check("to_pre_done", done, 1'b0);
    run_cycle(0, 0, 0, 0);
    check("to_flags", {done, pass, fail, timeout}, 4'b1001);
    check("to_cycle", cycle_count, 32'd49);
    check("to_cpu_reset", cpu_reset, 1'b1);

    // Overflow: first 16 kept, 4 dropped, push alongside a pop while full is kept
    trace_ready = 1'b0;
    run_start(1'b0);
    for (int i = 0; i < 20; i++) run_cycle(1, 5'd3, 32'(i), i < 16);
    check("ovf_valid", trace_valid, 1'b1);
    check("ovf_dropped", dropped, 8'd4);
    trace_ready = 1'b1;
    run_cycle(1, 5'd3, 32'd100, 1);
    run_cycle(0, 0, 0, 0);
    run_cycle(1, 5'd2, PASS_V, 1);
    check("ovf_dropped_after", dropped, 8'd4);
    check("ovf_pass", {done, pass}, 2'b11);
    drain();

    // Register 0 and reset-hold writes are filtered; then async reset mid-run
    run_start(1'b1);
    for (int i = 0; i < 3; i++) run_cycle(1, 5'd0, 32'hDEAD, 0);
    check("filter_valid", trace_valid, 1'b0);
    trace_ready = 1'b0;
    while (rc < 20) run_cycle(1, 5'd6, 32'(rc), 0);
    check("pre_rst_dropped", dropped, 8'd1);
    check("pre_rst_valid", trace_valid, 1'b1);
    check("pre_rst_cycle", cycle_count, 32'd20);
    #2 reset = 1'b0;
    #1;
    check("async_cpu_reset", cpu_reset, 1'b1);
    check("async_flags", {done, pass, fail, timeout}, 4'b0000);
    check("async_counts", {cycle_count, dropped}, 40'd0);
    check("async_trace", {trace_valid, trace_cycle, trace_address, trace_data}, 70'd0);
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    check("post_rst_idle", {cpu_reset, done}, 2'b10);

    // Stale trace and drops are flushed by a start from DONE
    run_start(1'b0);
    for (int i = 0; i < 18; i++) run_cycle(1, 5'd7, 32'(i), 0);
    run_cycle(1, 5'd2, PASS_V, 0);
    check("stale_done", {done, pass}, 2'b11);
    check("stale_dropped", dropped, 8'd3);
    check("stale_valid", trace_valid, 1'b1);
    run_start(1'b0);
    trace_ready = 1'b1;
    run_cycle(1, 5'd9, 32'hABC, 1);
    run_cycle(0, 0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
